// File: rtl/zoom_level_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// zoom_level_sequencer_pkg
//   Shared types for the zoom-level sequencer: algorithm codes, FSM states and
//   the helper that maps an algorithm to its scaling direction.
// -----------------------------------------------------------------------------
package zoom_level_sequencer_pkg;

  // Scaling algorithm select. NN/PR enlarge the image, DC/BA shrink it.
  typedef enum logic [1:0] {
    S_NN = 2'b00,
    S_PR = 2'b01,
    S_DC = 2'b10,
    S_BA = 2'b11
  } alg_e;

  // Configuration handshake states.
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_PEND = 2'b01,
    S_REQ  = 2'b10
  } state_e;

  // 1 when the algorithm belongs to the upscale class.
  function automatic logic is_upscale(input alg_e alg);
    return (alg == S_NN) || (alg == S_PR);
  endfunction

endpackage

// File: rtl/zoom_level_sequencer_btn_debounce.sv
// -----------------------------------------------------------------------------
// zoom_level_sequencer_btn_debounce
//   Counter-based debouncer for one button. The stable level follows the raw
//   input only after DEBOUNCE_CYC consecutive samples that disagree with it.
//   A rising edge of the stable level produces a one-cycle pulse, but only once
//   the button has been seen released since reset, so a button held through
//   reset release never fires.
//   The raw input is expected to be synchronous to clk (board-level
//   synchroniser upstream).
// Ports
//   clk       in   system clock
//   rst_n     in   asynchronous active-low reset
//   i_btn     in   raw button level, active-high
//   o_stable  out  debounced button level
//   o_rise    out  one-cycle pulse on a debounced press
// -----------------------------------------------------------------------------
module zoom_level_sequencer_btn_debounce #(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_stable,
  output logic o_rise
);

  localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_armed;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_armed  <= 1'b0;
      o_stable <= 1'b0;
      o_rise   <= 1'b0;
    end else begin
      o_rise <= 1'b0;
      if (!i_btn) r_armed <= 1'b1;
      if (i_btn == o_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYC - 1)) begin
        // This is the DEBOUNCE_CYC-th disagreeing sample in a row.
        o_stable <= i_btn;
        r_cnt    <= '0;
        o_rise   <= i_btn & r_armed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/zoom_level_sequencer.sv
// -----------------------------------------------------------------------------
// zoom_level_sequencer
//   Zoom-level controller for the scaling coprocessor. Debounced zoom buttons
//   move a target level; a new level/direction is handed to the scaler only
//   through a REQ/ACK handshake started while the engine is idle.
// Ports
//   clk               in   system clock
//   rst_n             in   asynchronous active-low reset
//   i_zoom_in_btn     in   raw zoom-in button
//   i_zoom_out_btn    in   raw zoom-out button
//   i_algorithm       in   00 NN, 01 PR (up), 10 DC, 11 BA (down)
//   i_engine_idle     in   scaler may take a new configuration
//   i_cfg_ack         in   scaler accepted o_cfg_* / geometry (1-cycle pulse)
//   o_cfg_req         out  configuration pending; outputs stable while high
//   o_shift_factor    out  committed level
//   o_scale_up        out  1 = upscale, 0 = downscale
//   o_img_width_out   out  committed output width
//   o_img_height_out  out  committed output height
// -----------------------------------------------------------------------------
module zoom_level_sequencer
  import zoom_level_sequencer_pkg::*;
#(
  parameter  int IMG_WIDTH_IN  = 160,
  parameter  int IMG_HEIGHT_IN = 120,
  parameter  int MAX_UP_LVL    = 3,
  parameter  int MAX_DN_LVL    = 2,
  parameter  int DEBOUNCE_CYC  = 16,
  parameter  int WRAP_EN       = 1,
  parameter  int LVL_W         = 2,
  localparam int W_OUT         = $clog2(IMG_WIDTH_IN << MAX_UP_LVL) + 1,
  localparam int H_OUT         = $clog2(IMG_HEIGHT_IN << MAX_UP_LVL) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_zoom_in_btn,
  input  logic             i_zoom_out_btn,
  input  logic [1:0]       i_algorithm,
  input  logic             i_engine_idle,
  input  logic             i_cfg_ack,
  output logic             o_cfg_req,
  output logic [LVL_W-1:0] o_shift_factor,
  output logic             o_scale_up,
  output logic [W_OUT-1:0] o_img_width_out,
  output logic [H_OUT-1:0] o_img_height_out
);

  localparam logic [W_OUT-1:0] W_IN = W_OUT'(IMG_WIDTH_IN);
  localparam logic [H_OUT-1:0] H_IN = H_OUT'(IMG_HEIGHT_IN);

  logic             w_in_ev;
  logic             w_out_ev;
  logic             w_in_stable;
  logic             w_out_stable;
  logic             w_unused_stable;
  logic             w_class_up;
  logic [LVL_W-1:0] w_lvl_max;
  logic             w_dirty;

  logic [LVL_W-1:0] r_target;
  logic             r_cls;
  logic [LVL_W-1:0] r_active;
  state_e           r_state;

  zoom_level_sequencer_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_in (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_btn    (i_zoom_in_btn),
    .o_stable (w_in_stable),
    .o_rise   (w_in_ev)
  );

  zoom_level_sequencer_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_out (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_btn    (i_zoom_out_btn),
    .o_stable (w_out_stable),
    .o_rise   (w_out_ev)
  );

  // Only the press pulses steer the level; the stable levels are spare.
  assign w_unused_stable = w_in_stable ^ w_out_stable;

  assign w_class_up = is_upscale(alg_e'(i_algorithm));
  assign w_lvl_max  = w_class_up ? LVL_W'(MAX_UP_LVL) : LVL_W'(MAX_DN_LVL);
  // Work to do whenever the requested level or direction differs from the
  // committed configuration.
  assign w_dirty    = (r_target != r_active) || (r_cls != o_scale_up);

  // Target level: follows button events continuously, regardless of handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_target <= '0;
      r_cls    <= 1'b1;
    end else begin
      r_cls <= w_class_up;
      if (w_class_up != r_cls) begin
        // A direction change invalidates the old level; it beats any event.
        r_target <= '0;
      end else if (w_in_ev && !w_out_ev) begin
        if (r_target >= w_lvl_max) r_target <= (WRAP_EN != 0) ? '0 : r_target;
        else                       r_target <= r_target + 1'b1;
      end else if (w_out_ev && !w_in_ev) begin
        if (r_target != '0) r_target <= r_target - 1'b1;
      end
    end
  end

  // Handshake FSM. The configuration outputs are registers loaded only on
  // entry to S_REQ, so they cannot move while o_cfg_req is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state          <= S_IDLE;
      r_active         <= '0;
      o_cfg_req        <= 1'b0;
      o_shift_factor   <= '0;
      o_scale_up       <= 1'b1;
      o_img_width_out  <= W_IN;
      o_img_height_out <= H_IN;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_dirty) r_state <= S_PEND;
        end
        S_PEND: begin
          if (!w_dirty) begin
            r_state <= S_IDLE;
          end else if (i_engine_idle) begin
            o_shift_factor   <= r_target;
            o_scale_up       <= r_cls;
            o_img_width_out  <= r_cls ? (W_IN << r_target) : (W_IN >> r_target);
            o_img_height_out <= r_cls ? (H_IN << r_target) : (H_IN >> r_target);
            o_cfg_req        <= 1'b1;
            r_state          <= S_REQ;
          end
        end
        S_REQ: begin
          if (i_cfg_ack) begin
            r_active  <= o_shift_factor;
            o_cfg_req <= 1'b0;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zoom_level_sequencer.sv
// -----------------------------------------------------------------------------
// tb_zoom_level_sequencer
//   Two instances share all stimulus except CFG_ACK: u_wrap (WRAP_EN=1) and
//   u_sat (WRAP_EN=0). A behavioural model predicts every output of both on
//   every cycle; directed scenarios add hand-computed expectations.
// -----------------------------------------------------------------------------
module tb_zoom_level_sequencer;

  localparam int DEB   = 16;
  localparam int WI    = 160;
  localparam int HI    = 120;
  localparam int MUP   = 3;
  localparam int MDN   = 2;
  localparam int LVL_W = 2;
  localparam int W_OUT = 12;  // ceil(log2(1280)) + 1
  localparam int H_OUT = 11;  // ceil(log2(960)) + 1

  logic             clk = 1'b0;
  logic             rst_n;
  logic             btn_in = 1'b0;
  logic             btn_out = 1'b0;
  logic [1:0]       alg = 2'b00;
  logic             engine_idle = 1'b1;
  logic             ack [2];
  logic             req [2];
  logic [LVL_W-1:0] sf  [2];
  logic             sup [2];
  logic [W_OUT-1:0] w   [2];
  logic [H_OUT-1:0] h   [2];

  bit auto_ack   [2] = '{1'b1, 1'b1};
  bit manual_ack [2] = '{1'b0, 1'b0};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int req_rises0 = 0;
  bit req_prev0 = 1'b0;

  always #5 clk = ~clk;

  zoom_level_sequencer #(.WRAP_EN(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .i_zoom_in_btn(btn_in), .i_zoom_out_btn(btn_out),
    .i_algorithm(alg), .i_engine_idle(engine_idle), .i_cfg_ack(ack[0]),
    .o_cfg_req(req[0]), .o_shift_factor(sf[0]), .o_scale_up(sup[0]),
    .o_img_width_out(w[0]), .o_img_height_out(h[0])
  );

  zoom_level_sequencer #(.WRAP_EN(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .i_zoom_in_btn(btn_in), .i_zoom_out_btn(btn_out),
    .i_algorithm(alg), .i_engine_idle(engine_idle), .i_cfg_ack(ack[1]),
    .o_cfg_req(req[1]), .o_shift_factor(sf[1]), .o_scale_up(sup[1]),
    .o_img_width_out(w[1]), .o_img_height_out(h[1])
  );

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: a value becomes the stable level once it has been seen on
  // DEB consecutive samples; a press counts only after a release was seen.
  int run     [2] = '{0, 0};
  bit run_val [2] = '{1'b0, 1'b0};
  bit stable  [2] = '{1'b0, 1'b0};
  bit armed   [2] = '{1'b0, 1'b0};
  bit m_ev    [2] = '{1'b0, 1'b0};   // [0] zoom-in press, [1] zoom-out press
  // Per instance: level bookkeeping and handshake.
  int m_tgt  [2] = '{0, 0};
  bit m_cls  [2] = '{1'b1, 1'b1};
  int m_act  [2] = '{0, 0};
  bit m_pend [2] = '{1'b0, 1'b0};
  bit m_req  [2] = '{1'b0, 1'b0};
  int m_sf   [2] = '{0, 0};
  bit m_sup  [2] = '{1'b1, 1'b1};
  int m_w    [2] = '{WI, WI};
  int m_h    [2] = '{HI, HI};

  task automatic model_reset();
    for (int b = 0; b < 2; b++) begin
      run[b] = 0; run_val[b] = 1'b0; stable[b] = 1'b0; armed[b] = 1'b0; m_ev[b] = 1'b0;
      m_tgt[b] = 0; m_cls[b] = 1'b1; m_act[b] = 0; m_pend[b] = 1'b0; m_req[b] = 1'b0;
      m_sf[b] = 0; m_sup[b] = 1'b1; m_w[b] = WI; m_h[b] = HI;
    end
  endtask

  task automatic model_step();
    bit cls_now;
    bit dirty;
    bit smp;
    int mx;
    cls_now = (alg == 2'b00) || (alg == 2'b01);
    for (int i = 0; i < 2; i++) begin
      dirty = (m_tgt[i] != m_act[i]) || (m_cls[i] != m_sup[i]);
      if (m_req[i]) begin
        if (ack[i]) begin
          m_act[i] = m_sf[i];
          m_req[i] = 1'b0;
        end
      end else if (m_pend[i]) begin
        if (!dirty) begin
          m_pend[i] = 1'b0;
        end else if (engine_idle) begin
          m_pend[i] = 1'b0;
          m_req[i]  = 1'b1;
          m_sf[i]   = m_tgt[i];
          m_sup[i]  = m_cls[i];
          m_w[i]    = m_cls[i] ? WI * (1 << m_tgt[i]) : WI / (1 << m_tgt[i]);
          m_h[i]    = m_cls[i] ? HI * (1 << m_tgt[i]) : HI / (1 << m_tgt[i]);
        end
      end else if (dirty) begin
        m_pend[i] = 1'b1;
      end
      mx = cls_now ? MUP : MDN;
      if (cls_now != m_cls[i])         m_tgt[i] = 0;
      else if (m_ev[0] && !m_ev[1])    m_tgt[i] = (m_tgt[i] == mx) ? ((i == 0) ? 0 : mx) : m_tgt[i] + 1;
      else if (m_ev[1] && !m_ev[0])    m_tgt[i] = (m_tgt[i] == 0) ? 0 : m_tgt[i] - 1;
      m_cls[i] = cls_now;
    end
    for (int b = 0; b < 2; b++) begin
      smp = (b == 0) ? btn_in : btn_out;
      if (run[b] > 0 && smp == run_val[b]) run[b]++;
      else begin run_val[b] = smp; run[b] = 1; end
      m_ev[b] = 1'b0;
      if (run[b] >= DEB && stable[b] != smp) begin
        stable[b] = smp;
        m_ev[b]   = smp && armed[b];
      end
      if (!smp) armed[b] = 1'b1;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Compare process: every cycle, both instances, away from the clock edge.
  always @(negedge clk) begin
    cyc++;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("c%0d u%0d req", cyc, i),    int'(req[i]), int'(m_req[i]));
      check($sformatf("c%0d u%0d shift", cyc, i),  int'(sf[i]),  m_sf[i]);
      check($sformatf("c%0d u%0d up", cyc, i),     int'(sup[i]), int'(m_sup[i]));
      check($sformatf("c%0d u%0d width", cyc, i),  int'(w[i]),   m_w[i]);
      check($sformatf("c%0d u%0d height", cyc, i), int'(h[i]),   m_h[i]);
    end
    if (req[0] && !req_prev0) req_rises0++;
    req_prev0 = req[0];
  end

  // Scaler stand-in: answers each REQ with a one-cycle ACK, or replays a
  // manual pulse when auto-acknowledge is off.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++)
      ack[i] = auto_ack[i] ? (req[i] && !ack[i]) : manual_ack[i];
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic press(input bit use_out);
    if (use_out) btn_out = 1'b1; else btn_in = 1'b1;
    repeat (20) tick();
    btn_in = 1'b0; btn_out = 1'b0;
    repeat (20) tick();
  endtask

  task automatic wait_req(input int idx, input int budget, output int n);
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      tick();
      if (req[idx]) begin
        n = k;
        return;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    int exp_w0 [4] = '{320, 640, 1280, 160};
    int exp_h0 [4] = '{240, 480, 960, 120};
    int exp_w1 [4] = '{320, 640, 1280, 1280};
    int dc_w0  [3] = '{80, 40, 160};
    int dc_w1  [3] = '{80, 40, 40};
    int dc_h1  [3] = '{60, 30, 30};

    ack[0] = 1'b0; ack[1] = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    check("reset req", int'(req[0]), 0);
    check("reset width", int'(w[0]), 160);
    check("reset height", int'(h[0]), 120);
    check("reset up", int'(sup[0]), 1);
    check("reset shift", int'(sf[0]), 0);
    rst_n = 1'b1;
    tick();

    // 1: NN, four zoom-ins, wrap on u_wrap, saturate on u_sat.
    for (int k = 0; k < 4; k++) begin
      press(1'b0);
      check($sformatf("t1 wrap width %0d", k), int'(w[0]), exp_w0[k]);
      check($sformatf("t1 wrap height %0d", k), int'(h[0]), exp_h0[k]);
      check($sformatf("t1 sat width %0d", k), int'(w[1]), exp_w1[k]);
    end

    // 2: DC, three zoom-ins; u_sat stops at level 2.
    alg = 2'b10;
    repeat (8) tick();
    check("t2 class switch width", int'(w[1]), 160);
    check("t2 class switch up", int'(sup[1]), 0);
    for (int k = 0; k < 3; k++) begin
      press(1'b0);
      check($sformatf("t2 sat width %0d", k), int'(w[1]), dc_w1[k]);
      check($sformatf("t2 sat height %0d", k), int'(h[1]), dc_h1[k]);
      check($sformatf("t2 wrap width %0d", k), int'(w[0]), dc_w0[k]);
    end
    check("t2 sat shift", int'(sf[1]), 2);

    // 3: bouncing zoom-in, then a steady press.
    base = req_rises0;
    for (int k = 0; k < 12; k++) begin
      btn_in = ~btn_in;
      repeat (5) tick();
    end
    btn_in = 1'b1;
    wait_req(0, 40, n);
    check("t3 req latency after last toggle", n, DEB + 3);
    repeat (10) tick();
    btn_in = 1'b0;
    repeat (20) tick();
    check("t3 single event", req_rises0 - base, 1);
    check("t3 shift", int'(sf[0]), 1);

    // 4: NN level 2 committed, then switch to BA.
    alg = 2'b00;
    repeat (8) tick();
    press(1'b0);
    press(1'b0);
    check("t4 nn width", int'(w[0]), 640);
    check("t4 nn shift", int'(sf[0]), 2);
    alg = 2'b11;
    wait_req(0, 10, n);
    check("t4 req latency", n, 3);
    check("t4 ba width", int'(w[0]), 160);
    check("t4 ba height", int'(h[0]), 120);
    check("t4 ba up", int'(sup[0]), 0);
    repeat (4) tick();

    // 5: engine busy while two presses queue up.
    engine_idle = 1'b0;
    base = req_rises0;
    press(1'b0);
    press(1'b0);
    repeat (10) tick();
    check("t5 no req while busy", req_rises0 - base, 0);
    auto_ack[0] = 1'b0;
    engine_idle = 1'b1;
    wait_req(0, 5, n);
    check("t5 req latency", n, 1);
    check("t5 shift", int'(sf[0]), 2);
    check("t5 width", int'(w[0]), 40);
    check("t5 height", int'(h[0]), 30);
    repeat (10) tick();
    check("t5 req held", int'(req[0]), 1);
    check("t5 width held", int'(w[0]), 40);
    auto_ack[0] = 1'b1;
    tick();
    check("t5 req drop after ack", int'(req[0]), 0);
    check("t5 single req", req_rises0 - base, 1);

    // 6: reset in the middle of a handshake.
    auto_ack[0] = 1'b0; auto_ack[1] = 1'b0;
    press(1'b0);
    check("t6 req pending", int'(req[0]), 1);
    #1 rst_n = 1'b0;
    #1;
    check("t6 reset req", int'(req[0]), 0);
    check("t6 reset width", int'(w[0]), 160);
    check("t6 reset height", int'(h[0]), 120);
    check("t6 reset up", int'(sup[0]), 1);
    alg = 2'b00;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    manual_ack[0] = 1'b1;
    tick();
    manual_ack[0] = 1'b0;
    repeat (3) tick();
    check("t6 stray ack req", int'(req[0]), 0);
    check("t6 stray ack shift", int'(sf[0]), 0);
    check("t6 stray ack width", int'(w[0]), 160);
    auto_ack[0] = 1'b1; auto_ack[1] = 1'b1;

    // 7: zoom-in held through reset release.
    btn_in = 1'b1;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    base = req_rises0;
    repeat (40) tick();
    check("t7 held button no req", req_rises0 - base, 0);
    check("t7 held button shift", int'(sf[0]), 0);
    btn_in = 1'b0;
    repeat (20) tick();
    press(1'b0);
    check("t7 re-press shift", int'(sf[0]), 1);
    check("t7 re-press width", int'(w[0]), 320);
    check("t7 re-press height", int'(h[0]), 240);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
